ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_code_fifo.sv | 85 ++++++++
 rtl/ps2_key_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - frame_state_t : frame FSM state encoding (IDLE, DATA, PARITY, STOP)
//   - PREFIX_EXPAND / PREFIX_RELEASE : scan-code prefix bytes (E0 / F0)
//   - CODE_W        : width of a decoded code {expand, release, scan byte}
//   - parity_ok()   : odd-parity check of a received byte plus parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int CODE_W = 10;

  localparam logic [7:0] PREFIX_EXPAND  = 8'hE0;
  localparam logic [7:0] PREFIX_RELEASE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // PS/2 uses odd parity: the nine bits together carry an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// ---------------------------------------------------------------------------
// ps2_code_fifo
// First-word-fallthrough FIFO for decoded key codes.
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data this cycle
//   push_data   : code to store
//   pop_ready   : consumer accept; pops only while head_valid is high
//   head_data   : oldest entry (0 while empty)
//   head_valid  : FIFO not empty
//   count       : current occupancy, 0..DEPTH
//   overflow    : one-cycle pulse when a push is dropped because the FIFO is
//                 full and nothing is popped in the same cycle
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ps2_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  // Storage has no reset: stale entries are never visible because the head
  // output is masked while the FIFO is empty.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic empty;
  logic full;
  logic pop;
  logic wr_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W + 1)'(DEPTH));
  assign pop   = pop_ready && !empty;

  // A full FIFO still takes a push when the head leaves in the same cycle;
  // in that case wr_ptr == rd_ptr and the slot being freed is reused.
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Fall-through read: the head is visible in the same cycle it is valid.
  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem[rd_ptr_reg];
  assign count      = count_reg;

endmodule

// File: rtl/ps2_key_rx.sv
// ---------------------------------------------------------------------------
// ps2_key_rx
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 clock,
// deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop),
// folds E0/F0 prefixes into flags and queues {expand, release, byte} codes.
//   clk, rst    : system clock, asynchronous active-high reset
//   ps2_clk     : raw PS/2 clock (asynchronous)
//   ps2_data    : raw PS/2 data (asynchronous)
//   code_data   : FIFO head {expand, release, scan byte}
//   code_valid  : FIFO not empty
//   code_ready  : consumer accept (pop when code_valid && code_ready)
//   fifo_count  : FIFO occupancy
//   err_parity  : one-cycle pulse on a parity failure
//   err_frame   : one-cycle pulse on a bad stop bit or an inter-edge timeout
//   overflow    : one-cycle pulse when a code is dropped (FIFO full)
// ---------------------------------------------------------------------------
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [CODE_W-1:0]           code_data,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_parity,
  output logic                        err_frame,
  output logic                        overflow
);

  localparam int FILT_W = $clog2(FILTER_LEN) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC) + 1;

  // -------------------------------------------------------------------------
  // Two-flop synchronizers, bit 0 = ps2_clk, bit 1 = ps2_data. Both reset
  // high so an idle bus never looks like a falling edge coming out of reset.
  // -------------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] sync_bits;

  assign raw_in = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  logic sync_clk;
  logic sync_data;

  assign sync_clk  = sync_bits[0];
  assign sync_data = sync_bits[1];

  // -------------------------------------------------------------------------
  // Clock de-glitch filter: the filtered level follows the synchronized clock
  // only after FILTER_LEN consecutive samples disagree with it. Any agreeing
  // sample restarts the run.
  // -------------------------------------------------------------------------
  logic [FILT_W-1:0] filt_cnt_reg;
  logic              filt_level_reg;
  logic              filt_flip;
  logic              fall;

  assign filt_flip = (sync_clk != filt_level_reg) &&
                     (filt_cnt_reg == FILT_W'(FILTER_LEN - 1));

  // Edge is flagged in the cycle the filter commits to the new low level, so
  // the frame logic samples sync_data in that same cycle.
  assign fall = filt_flip && filt_level_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_reg   <= '0;
      filt_level_reg <= 1'b1;
    end else if (sync_clk == filt_level_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_flip) begin
      filt_cnt_reg   <= '0;
      filt_level_reg <= sync_clk;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + FILT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  frame_state_t      state_reg,       state_next;
  logic [2:0]        bit_cnt_reg,     bit_cnt_next;
  logic [7:0]        shift_reg,       shift_next;
  logic              parity_reg,      parity_next;
  logic [TO_W-1:0]   to_cnt_reg,      to_cnt_next;
  logic              expand_reg,      expand_next;
  logic              release_reg,     release_next;
  logic              push_reg,        push_next;
  logic [CODE_W-1:0] push_code_reg,   push_code_next;
  logic              err_parity_reg,  err_parity_next;
  logic              err_frame_reg,   err_frame_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      to_cnt_reg     <= '0;
      expand_reg     <= 1'b0;
      release_reg    <= 1'b0;
      push_reg       <= 1'b0;
      push_code_reg  <= '0;
      err_parity_reg <= 1'b0;
      err_frame_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      to_cnt_reg     <= to_cnt_next;
      expand_reg     <= expand_next;
      release_reg    <= release_next;
      push_reg       <= push_next;
      push_code_reg  <= push_code_next;
      err_parity_reg <= err_parity_next;
      err_frame_reg  <= err_frame_next;
    end
  end

  logic timeout;

  // Counts clocks since the last falling edge while a frame is in progress.
  assign timeout = (state_reg != IDLE) && !fall &&
                   (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_next     = parity_reg;
    to_cnt_next     = to_cnt_reg;
    expand_next     = expand_reg;
    release_next    = release_reg;
    push_next       = 1'b0;
    push_code_next  = push_code_reg;
    err_parity_next = 1'b0;
    err_frame_next  = 1'b0;

    if ((state_reg == IDLE) || fall) begin
      to_cnt_next = '0;
    end else begin
      to_cnt_next = to_cnt_reg + TO_W'(1);
    end

    case (state_reg)
      IDLE: begin
        // A high sample here is line noise or a stray edge, not a start bit.
        if (fall && !sync_data) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end

      DATA: begin
        if (fall) begin
          shift_next   = {sync_data, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
      end

      PARITY: begin
        if (fall) begin
          parity_next = sync_data;
          state_next  = STOP;
        end
      end

      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (!sync_data) begin
            // A missing stop bit means the framing is lost; it outranks parity.
            err_frame_next = 1'b1;
            expand_next    = 1'b0;
            release_next   = 1'b0;
          end else if (!parity_ok(shift_reg, parity_reg)) begin
            err_parity_next = 1'b1;
            expand_next     = 1'b0;
            release_next    = 1'b0;
          end else if (shift_reg == PREFIX_EXPAND) begin
            expand_next = 1'b1;
          end else if (shift_reg == PREFIX_RELEASE) begin
            release_next = 1'b1;
          end else begin
            push_next      = 1'b1;
            push_code_next = {expand_reg, release_reg, shift_reg};
            expand_next    = 1'b0;
            release_next   = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (timeout) begin
      state_next     = IDLE;
      err_frame_next = 1'b1;
      expand_next    = 1'b0;
      release_next   = 1'b0;
    end
  end

  assign err_parity = err_parity_reg;
  assign err_frame  = err_frame_reg;

  // -------------------------------------------------------------------------
  // Code FIFO. Flags are cleared on every non-prefix byte regardless of
  // whether the FIFO had room, so a dropped code never leaks its prefixes.
  // -------------------------------------------------------------------------
  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_reg),
    .push_data  (push_code_reg),
    .pop_ready  (code_ready),
    .head_data  (code_data),
    .head_valid (code_valid),
    .count      (fifo_count),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

  localparam int DEPTH    = 8;
  localparam int FILT     = 4;
  localparam int TOUT     = 300;
  localparam int HALF     = 10;
  // Clocks from driving ps2_clk low to the edge on which the receiver takes
  // the falling edge: 2 synchronizer flops + FILT filter samples.
  localparam int EDGE_LAT = FILT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_ready = 1'b0;
  logic [9:0] code_data;
  logic       code_valid;
  logic [3:0] fifo_count;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_key_rx #(
    .FIFO_DEPTH  (DEPTH),
    .FILTER_LEN  (FILT),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_data  (code_data),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pulse counters and scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_parity) n_par++;
      if (err_frame)  n_frm++;
      if (overflow)   n_ovf++;
      if (code_valid && code_ready) begin
        check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          $display("pop code %03h (expected %03h)", code_data, e);
          check("pop_code", 32'(code_data), 32'(e));
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    $display("frame %02h sent (bad_par=%0b bad_stop=%0b)", b, bad_par, bad_stop);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || code_valid) && k < 300) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    int par0, frm0, ovf0;
    logic [7:0] b;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_code_data",  32'(code_data),  32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_errs", 32'({err_parity, err_frame, overflow}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // ---------------- single frame 0x1C with push latency ----------------
    b = 8'h1C;
    exp_q.push_back(10'h01C);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b));
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (EDGE_LAT) @(posedge clk);
    @(negedge clk);
    check("lat_valid_before", 32'(code_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid_after", 32'(code_valid), 32'd1);
    check("f1c_code_data",   32'(code_data),  32'h01C);
    check("f1c_fifo_count",  32'(fifo_count), 32'd1);
    @(posedge clk); #1 ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    $display("frame 1c sent (latency probe)");
    #1 code_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("f1c_popped_valid", 32'(code_valid), 32'd0);
    wait_drain("f1c");

    // ---------------- E0 F0 75 then 1C ----------------
    par0 = n_par; frm0 = n_frm;
    exp_q.push_back(10'h375);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain("prefix");
    check("prefix_no_errs", 32'(n_par + n_frm), 32'(par0 + frm0));

    // ---------------- bad parity, then F0 1C ----------------
    par0 = n_par;
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("badpar_pulse", 32'(n_par), 32'(par0 + 1));
    check("badpar_no_push", 32'(fifo_count), 32'd0);
    exp_q.push_back(10'h11C);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain("badpar");

    // ---------------- E0 then bad stop clears flags ----------------
    par0 = n_par; frm0 = n_frm;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1);
    @(negedge clk);
    check("badstop_frame_pulse", 32'(n_frm), 32'(frm0 + 1));
    check("badstop_no_parity",   32'(n_par), 32'(par0));
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain("badstop");

    // ---------------- overflow ----------------
    #1 code_ready = 1'b0;
    ovf0 = n_ovf;
    for (int i = 1; i <= 9; i++) begin
      if (i <= DEPTH) exp_q.push_back(10'(i));
      send_frame(8'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    check("ovf_pulse",      32'(n_ovf),      32'(ovf0 + 1));
    check("ovf_fifo_count", 32'(fifo_count), 32'd8);
    check("ovf_head",       32'(code_data),  32'h001);
    @(posedge clk); #1 code_ready = 1'b1;
    wait_drain("ovf");

    // ---------------- timeout after start + 4 data bits ----------------
    frm0 = n_frm;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (EDGE_LAT + TOUT - 1 - HALF) @(posedge clk);
    @(negedge clk);
    check("tout_not_yet", 32'(err_frame), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("tout_err_frame", 32'(err_frame), 32'd1);
    repeat (3) @(negedge clk);
    check("tout_single_pulse", 32'(n_frm), 32'(frm0 + 1));
    $display("partial frame timed out");
    exp_q.push_back(10'h02A);
    send_frame(8'h2A, 1'b0, 1'b0);
    wait_drain("tout");

    // ---------------- short ps2_clk glitch ----------------
    par0 = n_par; frm0 = n_frm;
    @(posedge clk); #1 ps2_clk = 1'b0;
    repeat (FILT - 1) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (TOUT + 20) @(posedge clk);
    @(negedge clk);
    check("glitch_no_err", 32'(n_par + n_frm), 32'(par0 + frm0));
    $display("glitch of %0d cycles applied", FILT - 1);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_drain("glitch");

    // ---------------- reset mid-frame ----------------
    #1 code_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    check("prerst_fifo_count", 32'(fifo_count), 32'd1);
    par0 = n_par; frm0 = n_frm;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_code_valid", 32'(code_valid), 32'd0);
    check("midrst_code_data",  32'(code_data),  32'd0);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_errs", 32'({err_parity, err_frame, overflow}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    code_ready = 1'b1;
    $display("reset applied mid-frame");
    repeat (TOUT + 50) @(posedge clk);
    @(negedge clk);
    check("postrst_no_err", 32'(n_par + n_frm), 32'(par0 + frm0));
    check("postrst_valid",  32'(code_valid), 32'd0);
    exp_q.push_back(10'h033);
    send_frame(8'h33, 1'b0, 1'b0);
    wait_drain("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
